frame_seq_ctrl: RTL and testbench
=================================

// Module: frame_seq_ctrl
// PURPOSE
// Frame sequencer for the pixel-buffer memory. It drives the memory's on_off/rw/clear
// controls through CLEAR -> CAPTURE (camera write) -> DRAIN (read to grayscaler) per frame.
// It waits on the memory's done status, bounds each phase with a watchdog, and counts frames.
// It sits between the top-level control and the buffer memory.
// PARAMETERS
// N          5     image height in pixels
// M          5     image width in pixels
// TIMEOUT    1024  max clk cycles per phase before error; must exceed 3*N*M + pause time
// CNT_W      16    width of frame counter
// PORTS
// clk          in   1      clock, all state updates on rising edge
// rst_n        in   1      asynchronous active-low reset
// start        in   1      pulse: begin a frame sequence (ignored unless IDLE or ERROR)
// continuous   in   1      1: loop to next frame after DRAIN; sampled in FDONE
// clear_en     in   1      1: run CLEAR phase before CAPTURE; sampled on start
// abort        in   1      level: force IDLE, highest priority after reset
// cam_ready    in   1      camera has a frame ready; CAPTURE waits for it
// mem_done     in   1      memory phase-complete status
// mem_on_off   out  1      memory enable
// mem_rw       out  1      1 = write, 0 = read
// mem_clear    out  1      memory clear request
// busy         out  1      1 in any state except IDLE/ERROR
// frame_done   out  1      one-cycle pulse per completed frame
// error        out  1      sticky watchdog error flag
// frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W
// state        out  3      current state encoding, for debug
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; frame_count=0; watchdog=0; latched clear_en=0.
// - All outputs are registered. mem_* reflect the state entered on the same edge.
// - States, with the 3-bit encoding:
//   IDLE(0)    on_off=0. start -> CLEAR if clear_en, else -> CAPTURE.
//   CLEAR(1)   on_off=1, clear=1, rw=0. mem_done -> GAP1.
//   GAP1(2)    on_off=0 for exactly 1 cycle so the memory returns to inactive. -> CAPTURE.
//   CAPTURE(3) on_off=cam_ready, rw=1, clear=0.
//              Watchdog does not run while on_off=0.
//              mem_done while on_off=1 -> GAP2.
//   GAP2(4)    on_off=0 for 1 cycle. -> DRAIN.
//   DRAIN(5)   on_off=1, rw=0. Grayscaler pause is handled inside the memory; the
//              watchdog runs throughout. mem_done -> FDONE.
//   FDONE(6)   on_off=0; frame_done=1 for this cycle only; frame_count += 1.
//              continuous=1 -> CLEAR or CAPTURE, selected by the latched clear_en.
//              continuous=0 -> IDLE.
//   ERROR(7)   on_off=0, error=1. start -> behaves as from IDLE and clears error.
// - mem_done is combinational at the memory. It counts only when it is sampled high on a
//   rising edge while on_off=1 in the active phase. Any mem_done in IDLE/GAP/FDONE is ignored.
// - Watchdog: resets to 0 on entry to each active phase and increments each active cycle.
//   When it reaches TIMEOUT without mem_done -> ERROR. mem_done on that same edge wins.
// - abort=1 on any edge: next state IDLE, on_off=0, error cleared, frame_count kept.
//   abort overrides start.
// - start while busy is ignored. A start pulse is not queued.
// - Reset asserted mid-phase returns immediately to reset values.
//   The memory sees on_off=0 and goes inactive.
// - frame_count wraps from 2^CNT_W-1 to 0 with no flag.
// TESTING
// - Single frame: clear_en=1, continuous=0, start pulse.
//   Memory model asserts done after 75 cycles per phase.
//   -> CLEAR, GAP1, CAPTURE, GAP2, DRAIN, FDONE, IDLE; frame_done 1 pulse; frame_count=1.
// - Camera stall: cam_ready=0 for 300 cycles in CAPTURE with TIMEOUT=100.
//   -> mem_on_off=0 and no error; after cam_ready rises, capture completes normally.
// - Watchdog: mem_done never asserted in DRAIN with TIMEOUT=100.
//   -> ERROR exactly 100 active cycles after DRAIN entry; error=1, on_off=0.
//   -> A following start clears error.
// - Continuous: continuous=1, clear_en=0, run 3 frames.
//   -> 3 frame_done pulses, frame_count=3, no CLEAR state visited; busy stays 1.
// - Abort mid-CAPTURE after 20 cycles, with start asserted on the same edge.
//   -> IDLE next cycle, on_off=0, frame_count unchanged.
// - Reset and wrap: CNT_W=2, run 5 frames -> frame_count=1.
//   rst_n low mid-DRAIN -> all outputs 0 immediately.

Source files
------------

// File: rtl/frame_seq_ctrl_if.sv
// Control/status bundle between the frame sequencer and the pixel-buffer memory.
// The sequencer owns the controls; the memory answers with a combinational done.
interface frame_seq_ctrl_if;
  logic mem_on_off;
  logic mem_rw;
  logic mem_clear;
  logic mem_done;

  modport master (
    output mem_on_off,
    output mem_rw,
    output mem_clear,
    input  mem_done
  );

  modport slave (
    input  mem_on_off,
    input  mem_rw,
    input  mem_clear,
    output mem_done
  );
endinterface

// File: rtl/frame_seq_ctrl.sv
// Per-frame sequencer for the pixel-buffer memory: CLEAR -> CAPTURE -> DRAIN with a
// per-phase watchdog, sticky error and a wrapping completed-frame counter.
module frame_seq_ctrl #(
  parameter int unsigned N       = 5,
  parameter int unsigned M       = 5,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   clear_en,
  input  logic                   abort,
  input  logic                   cam_ready,
  frame_seq_ctrl_if.master       mem,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   error,
  output logic [CNT_W-1:0]       frame_count,
  output logic [2:0]             state
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  if (TIMEOUT <= 3 * N * M) begin : g_timeout_check
    $error("TIMEOUT too small for a full N*M frame phase");
  end

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StGap1    = 3'd2,
    StCapture = 3'd3,
    StGap2    = 3'd4,
    StDrain   = 3'd5,
    StFdone   = 3'd6,
    StError   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               clr_en_q, clr_en_d;
  logic               on_off_q, on_off_d;
  logic               rw_q, rw_d;
  logic               clear_q, clear_d;
  logic               busy_q, busy_d;
  logic               fdone_q, fdone_d;
  logic               error_q, error_d;
  logic               active, done_hit, timeout_hit;

  // mem_done only counts while the memory is actually enabled in an active phase.
  assign active      = on_off_q && (state_q inside {StClear, StCapture, StDrain});
  assign done_hit    = active && mem.mem_done;
  assign timeout_hit = active && !mem.mem_done && (wdog_q == WdogW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    clr_en_d = clr_en_q;
    unique case (state_q)
      StIdle, StError: begin
        if (start) begin
          clr_en_d = clear_en;
          state_d  = clear_en ? StClear : StCapture;
        end
      end
      StClear: begin
        if (done_hit)         state_d = StGap1;
        else if (timeout_hit) state_d = StError;
      end
      StGap1: state_d = StCapture;
      StCapture: begin
        if (done_hit)         state_d = StGap2;
        else if (timeout_hit) state_d = StError;
      end
      StGap2: state_d = StDrain;
      StDrain: begin
        if (done_hit)         state_d = StFdone;
        else if (timeout_hit) state_d = StError;
      end
      StFdone: begin
        if (continuous) state_d = clr_en_q ? StClear : StCapture;
        else            state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) wdog_d = '0;
    else if (active)        wdog_d = wdog_q + WdogW'(1);

    count_d = (state_d == StFdone) ? count_q + CNT_W'(1) : count_q;

    // Outputs are registered from the state being entered on this edge.
    on_off_d = 1'b0;
    rw_d     = 1'b0;
    clear_d  = 1'b0;
    unique case (state_d)
      StClear: begin
        on_off_d = 1'b1;
        clear_d  = 1'b1;
      end
      StCapture: begin
        on_off_d = cam_ready;
        rw_d     = 1'b1;
      end
      StDrain: on_off_d = 1'b1;
      default: ;
    endcase
    busy_d  = !(state_d inside {StIdle, StError});
    fdone_d = (state_d == StFdone);
    error_d = (state_d == StError);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wdog_q   <= '0;
      count_q  <= '0;
      clr_en_q <= 1'b0;
      on_off_q <= 1'b0;
      rw_q     <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      count_q  <= count_d;
      clr_en_q <= clr_en_d;
      on_off_q <= on_off_d;
      rw_q     <= rw_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      error_q  <= error_d;
    end
  end

  assign mem.mem_on_off = on_off_q;
  assign mem.mem_rw     = rw_q;
  assign mem.mem_clear  = clear_q;
  assign busy           = busy_q;
  assign frame_done     = fdone_q;
  assign error          = error_q;
  assign frame_count    = count_q;
  assign state          = state_q;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl with a simple latency-based memory model.
module tb_frame_seq_ctrl;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, continuous = 1'b0, clear_en = 1'b0;
  logic             abort = 1'b0, cam_ready = 1'b1;
  logic             busy, frame_done, error;
  logic [CNT_W-1:0] frame_count;
  logic [2:0]       state;

  frame_seq_ctrl_if mem_if ();

  frame_seq_ctrl #(
    .N(5), .M(5), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .clear_en    (clear_en),
    .abort       (abort),
    .cam_ready   (cam_ready),
    .mem         (mem_if.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .error       (error),
    .frame_count (frame_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Memory model: done after `lat` enabled cycles; can be muted during DRAIN.
  int lat = 75;
  bit block_drain = 1'b0;
  int mcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  mcnt <= 0;
    else if (!mem_if.mem_on_off) mcnt <= 0;
    else                         mcnt <= mcnt + 1;
  end
  assign mem_if.mem_done = mem_if.mem_on_off && (mcnt >= lat - 1) &&
                           !(block_drain && state == 3'd5);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int fd_pulses;
  bit saw_clear;
  bit busy_drop;
  int seq[$];

  task automatic run_to_idle(input string tag, input int max_cycles, input int stop_after);
    fd_pulses = 0;
    saw_clear = 1'b0;
    busy_drop = 1'b0;
    seq.delete();
    seq.push_back(int'(state));
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (int'(state) != seq[$]) seq.push_back(int'(state));
      if (frame_done) begin
        fd_pulses++;
        if (stop_after > 0 && fd_pulses >= stop_after) continuous = 1'b0;
      end
      if (state == 3'd1) saw_clear = 1'b1;
      if (state == 3'd0) break;
      if (!busy) busy_drop = 1'b1;
    end
    check_eq({tag, "_idle_reached"}, state, 0);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (state == s) break;
    end
    check_eq({tag, "_reached"}, state, s);
  endtask

  task automatic pulse_start(input logic ce);
    clear_en = ce;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    clear_en = 1'b0;
  endtask

  initial begin
    int exp_seq[7];
    int bad;
    exp_seq = '{1, 2, 3, 4, 5, 6, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_on_off", mem_if.mem_on_off, 0);
    check_eq("rst_rw", mem_if.mem_rw, 0);
    check_eq("rst_clear", mem_if.mem_clear, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fdone", frame_done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_count", frame_count, 0);
    rst_n = 1'b1;
    tick();

    // Single frame with CLEAR
    pulse_start(1'b1);
    check_eq("t1_state", state, 1);
    check_eq("t1_on_off", mem_if.mem_on_off, 1);
    check_eq("t1_clear", mem_if.mem_clear, 1);
    check_eq("t1_rw", mem_if.mem_rw, 0);
    check_eq("t1_busy", busy, 1);
    run_to_idle("t1", 1000, 0);
    check_eq("t1_seq_len", seq.size(), 7);
    for (int k = 0; k < 7 && k < seq.size(); k++)
      check_eq($sformatf("t1_seq%0d", k), seq[k], exp_seq[k]);
    check_eq("t1_pulses", fd_pulses, 1);
    check_eq("t1_count", frame_count, 1);
    check_eq("t1_busy_idle", busy, 0);

    // Camera stall: watchdog frozen while on_off is low
    cam_ready = 1'b0;
    pulse_start(1'b0);
    check_eq("t2_state", state, 3);
    check_eq("t2_on_off", mem_if.mem_on_off, 0);
    check_eq("t2_rw", mem_if.mem_rw, 1);
    bad = 0;
    repeat (300) begin
      tick();
      if (mem_if.mem_on_off || error || state != 3'd3) bad++;
    end
    check_eq("t2_stall_bad", bad, 0);
    cam_ready = 1'b1;
    tick();
    check_eq("t2_on_off_up", mem_if.mem_on_off, 1);
    run_to_idle("t2", 1000, 0);
    check_eq("t2_error", error, 0);
    check_eq("t2_pulses", fd_pulses, 1);
    check_eq("t2_count", frame_count, 2);

    // Watchdog in DRAIN
    block_drain = 1'b1;
    pulse_start(1'b0);
    wait_state("t3_drain", 3'd5, 500);
    repeat (99) tick();
    check_eq("t3_still_drain", state, 5);
    check_eq("t3_no_err_yet", error, 0);
    tick();
    check_eq("t3_state_err", state, 7);
    check_eq("t3_error", error, 1);
    check_eq("t3_on_off", mem_if.mem_on_off, 0);
    check_eq("t3_busy", busy, 0);
    check_eq("t3_count", frame_count, 2);
    block_drain = 1'b0;
    pulse_start(1'b0);
    check_eq("t3_err_clr", error, 0);
    check_eq("t3_restart", state, 3);
    run_to_idle("t3", 1000, 0);
    check_eq("t3_count_after", frame_count, 3);

    // Continuous, 3 frames, no CLEAR; count wraps 3 -> 2
    continuous = 1'b1;
    pulse_start(1'b0);
    run_to_idle("t4", 3000, 3);
    check_eq("t4_pulses", fd_pulses, 3);
    check_eq("t4_no_clear", saw_clear, 0);
    check_eq("t4_busy_drop", busy_drop, 0);
    check_eq("t4_count", frame_count, 2);

    // Abort mid-CAPTURE, start on the same edge
    pulse_start(1'b0);
    check_eq("t5_capture", state, 3);
    repeat (20) tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    check_eq("t5_state", state, 0);
    check_eq("t5_on_off", mem_if.mem_on_off, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_error", error, 0);
    check_eq("t5_count", frame_count, 2);
    abort = 1'b0;
    start = 1'b0;
    tick();
    check_eq("t5_not_queued", state, 0);

    // Reset, 5 frames with CNT_W=2 -> 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t6_count_rst", frame_count, 0);
    tick();
    continuous = 1'b1;
    pulse_start(1'b0);
    run_to_idle("t6", 5000, 5);
    check_eq("t6_pulses", fd_pulses, 5);
    check_eq("t6_count", frame_count, 1);

    // Asynchronous reset mid-DRAIN
    pulse_start(1'b0);
    wait_state("t7_drain", 3'd5, 500);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t7_state", state, 0);
    check_eq("t7_on_off", mem_if.mem_on_off, 0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_count", frame_count, 0);
    check_eq("t7_error", error, 0);
    check_eq("t7_fdone", frame_done, 0);
    #10 rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
